// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: fetch-slot pacing, PC / next-PC selection,
// stall hold, redirect capture and squash, and the IF/ID pipeline register.
module if_fetch_stage #(
  parameter int          PHASES   = 2,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = 16'h0800
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  input  logic [15:0] imem_instr,
  output logic [15:0] imem_address,
  output logic        slot_tick,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus1,
  output logic        ifid_valid
);
  localparam int            PW         = (PHASES > 2) ? $clog2(PHASES) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic [15:0]   pc_q, pc_d;
  logic [15:0]   fl_pc_q, fl_pc_d;
  logic          fl_valid_q, fl_valid_d;
  logic          redir_pend_q, redir_pend_d;
  logic [15:0]   redir_pc_q, redir_pc_d;
  logic [15:0]   ifid_instr_q, ifid_instr_d;
  logic [15:0]   ifid_pp1_q, ifid_pp1_d;
  logic          ifid_valid_q, ifid_valid_d;

  logic          boundary;
  logic          redir_eff;
  logic [15:0]   redir_tgt;

  assign boundary  = (phase_q == LAST_PHASE);
  assign redir_eff = redirect | redir_pend_q;
  // a request in the boundary cycle is the latest one, so it beats a pending target
  assign redir_tgt = redirect ? redirect_target : redir_pc_q;

  always_comb begin
    phase_d      = boundary ? '0 : phase_q + 1'b1;
    pc_d         = pc_q;
    fl_pc_d      = fl_pc_q;
    fl_valid_d   = fl_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pp1_d   = ifid_pp1_q;
    ifid_valid_d = ifid_valid_q;
    redir_pc_d   = redirect ? redirect_target : redir_pc_q;
    redir_pend_d = boundary ? 1'b0 : (redir_pend_q | redirect);

    if (boundary) begin
      if (redir_eff) begin
        pc_d         = redir_tgt;
        fl_valid_d   = 1'b0;
        ifid_instr_d = NOP_WORD;
        ifid_valid_d = 1'b0;
      end else if (!stall) begin
        // the word on imem_instr belongs to the address tagged in fl_pc
        ifid_instr_d = fl_valid_q ? imem_instr : NOP_WORD;
        ifid_pp1_d   = fl_pc_q + 16'd1;
        ifid_valid_d = fl_valid_q;
        fl_pc_d      = pc_q;
        fl_valid_d   = 1'b1;
        pc_d         = pc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase_q      <= '0;
      pc_q         <= RESET_PC;
      fl_pc_q      <= 16'h0000;
      fl_valid_q   <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 16'h0000;
      ifid_instr_q <= NOP_WORD;
      ifid_pp1_q   <= 16'h0000;
      ifid_valid_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      pc_q         <= pc_d;
      fl_pc_q      <= fl_pc_d;
      fl_valid_q   <= fl_valid_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pp1_q   <= ifid_pp1_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_address  = pc_q;
  assign slot_tick     = boundary;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc_plus1 = ifid_pp1_q;
  assign ifid_valid    = ifid_valid_q;

endmodule
